// File: rtl/dds_pkg.sv
// Shared definitions for the DDS output path: DAC word width, SPI driver FSM
// encodings and legal ranges for the driver's timing parameters.
package dds_pkg;

    localparam int DAC_WIDTH      = 16;
    localparam int BIT_CNT_W      = 5;
    localparam int HALF_CNT_W     = 8;

    localparam int CLK_DIV_MIN    = 1;
    localparam int CLK_DIV_MAX    = 255;
    localparam int GAP_CYCLES_MIN = 0;
    localparam int GAP_CYCLES_MAX = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        GAP   = 3'd4
    } dac_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period counter: pulses tick_o every CLK_DIV cycles and restarts from
// zero whenever the FSM enters a new state.
module sclk_tick_gen
    import dds_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o,
    output logic tick_next_o
);

    localparam logic [HALF_CNT_W-1:0] DIV_LAST = HALF_CNT_W'(CLK_DIV - 1);

    logic [HALF_CNT_W-1:0] cnt_q;
    logic [HALF_CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == DIV_LAST);

    always_comb begin
        cnt_d = cnt_q + HALF_CNT_W'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Lets the owner register an output that must coincide with the tick cycle.
    assign tick_next_o = (cnt_d == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_driver.sv
// Serialises 16-bit DDS samples to an SPI DAC (MSB first, data launched on the
// SCLK falling edge) and strobes LDAC after each word.
module dac_spi_driver
    import dds_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_INVERT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DAC_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 dac_cs_n,
    output logic                 dac_sclk,
    output logic                 dac_sdo,
    output logic                 dac_ldac_n,
    output logic                 frame_done
);

    if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
        $error("dac_spi_driver: CLK_DIV out of range 1..255");
    end
    if (GAP_CYCLES < GAP_CYCLES_MIN || GAP_CYCLES > GAP_CYCLES_MAX) begin : g_bad_gap
        $error("dac_spi_driver: GAP_CYCLES out of range 0..255");
    end

    localparam logic [DAC_WIDTH-1:0]  INV_MASK = MSB_INVERT ? {1'b1, {(DAC_WIDTH-1){1'b0}}} : '0;
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST = BIT_CNT_W'(DAC_WIDTH - 1);
    localparam logic [HALF_CNT_W-1:0] GAP_LAST = HALF_CNT_W'(GAP_CYCLES - 1);

    dac_state_e             state_q, state_d;
    logic [DAC_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [HALF_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   sdo_q, sdo_d;
    logic                   ldac_n_q, ldac_n_d;
    logic                   frame_done_q, frame_done_d;
    logic                   ready_q, ready_d;

    logic                   restart;
    logic                   tick;
    logic                   tick_next;
    logic [DAC_WIDTH-1:0]   din_cap;

    assign din_cap = din ^ INV_MASK;

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart_i   (restart),
        .tick_o      (tick),
        .tick_next_o (tick_next)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        unique case (state_q)
            IDLE: begin
                if (din_valid && ready_q) begin
                    shift_d   = din_cap;
                    sdo_d     = din_cap[DAC_WIDTH-1];
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = LATCH;
                        end else begin
                            // Rotate rather than shift so every register bit stays live.
                            shift_d   = {shift_q[DAC_WIDTH-2:0], shift_q[DAC_WIDTH-1]};
                            sdo_d     = shift_q[DAC_WIDTH-2];
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + HALF_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin levels are registered from the next state so they line up with state_q.
    assign restart      = (state_d != state_q);
    assign cs_n_d       = !((state_d == SETUP) || (state_d == SHIFT));
    assign ldac_n_d     = (state_d != LATCH);
    assign frame_done_d = (state_d == LATCH) && tick_next;
    assign ready_d      = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            sdo_q        <= 1'b0;
            ldac_n_q     <= 1'b1;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            sdo_q        <= sdo_d;
            ldac_n_q     <= ldac_n_d;
            frame_done_q <= frame_done_d;
            ready_q      <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign din_ready  = ready_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdo    = sdo_q;
    assign dac_ldac_n = ldac_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver: three instances cover the default-ish,
// minimum-divider and MSB-inverting configurations against hand-derived values.
module tb_dac_spi_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  vld_w = 3'b000;
    logic [15:0] din_w [3];
    logic [2:0]  rdy_w, cs_n_w, sclk_w, sdo_w, ldac_w, fd_w;

    dac_spi_driver #(.CLK_DIV(2), .GAP_CYCLES(2), .MSB_INVERT(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_w[0]), .din_valid(vld_w[0]), .din_ready(rdy_w[0]),
        .dac_cs_n(cs_n_w[0]), .dac_sclk(sclk_w[0]), .dac_sdo(sdo_w[0]),
        .dac_ldac_n(ldac_w[0]), .frame_done(fd_w[0]));

    dac_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(0), .MSB_INVERT(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_w[1]), .din_valid(vld_w[1]), .din_ready(rdy_w[1]),
        .dac_cs_n(cs_n_w[1]), .dac_sclk(sclk_w[1]), .dac_sdo(sdo_w[1]),
        .dac_ldac_n(ldac_w[1]), .frame_done(fd_w[1]));

    dac_spi_driver #(.CLK_DIV(2), .GAP_CYCLES(2), .MSB_INVERT(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .din(din_w[2]), .din_valid(vld_w[2]), .din_ready(rdy_w[2]),
        .dac_cs_n(cs_n_w[2]), .dac_sclk(sclk_w[2]), .dac_sdo(sdo_w[2]),
        .dac_ldac_n(ldac_w[2]), .frame_done(fd_w[2]));

    // Pin monitor, sampled on the falling clk edge.
    int          cyc = 0;
    int          rise_cnt [3]    = '{default:0};
    int          fd_cnt [3]      = '{default:0};
    int          acc_cnt [3]     = '{default:0};
    int          acc_cyc [3]     = '{default:0};
    int          acc_delta [3]   = '{default:0};
    int          fall_cyc [3]    = '{default:0};
    int          viol [3]        = '{default:0};
    int          tog [3]         = '{default:0};
    int          ld_fall [3]     = '{default:0};
    int          cs_run [3]      = '{default:0};
    int          last_cs_run [3] = '{default:0};
    int          ld_run [3]      = '{default:0};
    int          last_ld_run [3] = '{default:0};
    int          hi_run [3]      = '{default:0};
    int          last_hi_run [3] = '{default:0};
    logic [15:0] word [3]        = '{default:16'h0000};
    logic        p_cs [3]        = '{default:1'b1};
    logic        p_ld [3]        = '{default:1'b1};
    logic        p_sclk [3]      = '{default:1'b0};
    logic        p_sdo [3]       = '{default:1'b0};
    logic        p_rdy [3]       = '{default:1'b0};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (sclk_w[i] && !p_sclk[i]) begin
                rise_cnt[i] <= rise_cnt[i] + 1;
                word[i]     <= {word[i][14:0], sdo_w[i]};
            end
            if (fd_w[i]) fd_cnt[i] <= fd_cnt[i] + 1;
            if (vld_w[i] && rdy_w[i]) begin
                acc_cnt[i]   <= acc_cnt[i] + 1;
                acc_delta[i] <= cyc - acc_cyc[i];
                acc_cyc[i]   <= cyc;
            end
            if (!cs_n_w[i] && p_cs[i]) fall_cyc[i] <= cyc;
            if (!ldac_w[i] && p_ld[i]) ld_fall[i] <= ld_fall[i] + 1;
            if (!cs_n_w[i]) cs_run[i] <= cs_run[i] + 1;
            else if (!p_cs[i]) begin
                last_cs_run[i] <= cs_run[i];
                cs_run[i]      <= 0;
            end
            if (!ldac_w[i]) ld_run[i] <= ld_run[i] + 1;
            else if (!p_ld[i]) begin
                last_ld_run[i] <= ld_run[i];
                ld_run[i]      <= 0;
            end
            if (sclk_w[i]) hi_run[i] <= hi_run[i] + 1;
            else if (p_sclk[i]) begin
                last_hi_run[i] <= hi_run[i];
                hi_run[i]      <= 0;
            end
            if (rst_n && (sdo_w[i] != p_sdo[i]) && !(p_sclk[i] && !sclk_w[i])
                && !(p_cs[i] && !cs_n_w[i])) viol[i] <= viol[i] + 1;
            if ((cs_n_w[i] != p_cs[i]) || (sclk_w[i] != p_sclk[i]) ||
                (ldac_w[i] != p_ld[i]) || (rdy_w[i] != p_rdy[i])) tog[i] <= tog[i] + 1;
            p_cs[i]   <= cs_n_w[i];
            p_ld[i]   <= ldac_w[i];
            p_sclk[i] <= sclk_w[i];
            p_sdo[i]  <= sdo_w[i];
            p_rdy[i]  <= rdy_w[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int get_cnt(input int kind, input int idx);
        case (kind)
            0:       return acc_cnt[idx];
            1:       return fd_cnt[idx];
            default: return rise_cnt[idx];
        endcase
    endfunction

    localparam int K_ACC  = 0;
    localparam int K_FD   = 1;
    localparam int K_RISE = 2;

    task automatic wait_cnt(input string tag, input int kind, input int idx,
                            input int target, input int budget);
        int n = 0;
        while ((get_cnt(kind, idx) < target) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        if (get_cnt(kind, idx) < target) check({tag, "_timeout"}, get_cnt(kind, idx), target);
    endtask

    task automatic pulse(input int idx, input logic [15:0] d);
        @(posedge clk); #1;
        din_w[idx] = d;
        vld_w[idx] = 1'b1;
        @(posedge clk); #1;
        vld_w[idx] = 1'b0;
    endtask

    initial begin
        int b_rise, b_fd, b_acc, b_ld, b_tog0, b_tog1, b_tog2;
        for (int i = 0; i < 3; i++) din_w[i] = 16'h0000;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rdy_w, 3'b000);
        check("rst_cs_n", cs_n_w, 3'b111);
        check("rst_sclk", sclk_w, 3'b000);
        check("rst_sdo", sdo_w, 3'b000);
        check("rst_ldac_n", ldac_w, 3'b111);
        check("rst_frame_done", fd_w, 3'b000);
        rst_n = 1'b1;
        #1 check("ready_before_edge", rdy_w, 3'b000);
        @(posedge clk); #1;
        check("ready_first_edge", rdy_w, 3'b111);

        // Basic frame, CLK_DIV=2 GAP=2
        b_rise = rise_cnt[0]; b_fd = fd_cnt[0];
        pulse(0, 16'hA5C3);
        wait_cnt("basic_fd", K_FD, 0, b_fd + 1, 200);
        repeat (4) @(posedge clk);
        check("basic_rises", rise_cnt[0] - b_rise, 16);
        check("basic_word", word[0], 16'hA5C3);
        check("basic_cs_low", last_cs_run[0], 66);
        check("basic_ldac_low", last_ld_run[0], 2);
        check("basic_frame_done", fd_cnt[0] - b_fd, 1);
        check("basic_latency", fall_cyc[0] - acc_cyc[0], 1);
        check("basic_sclk_high", last_hi_run[0], 2);

        // Back-to-back with din_valid held; din change while busy is ignored
        b_rise = rise_cnt[0]; b_fd = fd_cnt[0]; b_acc = acc_cnt[0];
        @(posedge clk); #1;
        din_w[0] = 16'h0001;
        vld_w[0] = 1'b1;
        wait_cnt("b2b_acc1", K_ACC, 0, b_acc + 1, 20);
        #1 din_w[0] = 16'hFFFF;
        wait_cnt("b2b_fd1", K_FD, 0, b_fd + 1, 200);
        #1 check("b2b_word1", word[0], 16'h0001);
        wait_cnt("b2b_acc2", K_ACC, 0, b_acc + 2, 200);
        #1 vld_w[0] = 1'b0;
        check("b2b_period", acc_delta[0], 71);
        wait_cnt("b2b_fd2", K_FD, 0, b_fd + 2, 200);
        repeat (5) @(posedge clk);
        check("b2b_word2", word[0], 16'hFFFF);
        check("b2b_rises", rise_cnt[0] - b_rise, 32);
        check("b2b_accepts", acc_cnt[0] - b_acc, 2);

        // Minimum divider, CLK_DIV=1 GAP=0
        b_fd = fd_cnt[1]; b_acc = acc_cnt[1]; b_rise = rise_cnt[1];
        @(posedge clk); #1;
        din_w[1] = 16'h8000;
        vld_w[1] = 1'b1;
        wait_cnt("min_acc2", K_ACC, 1, b_acc + 2, 100);
        #1 vld_w[1] = 1'b0;
        check("min_period", acc_delta[1], 35);
        wait_cnt("min_fd2", K_FD, 1, b_fd + 2, 100);
        repeat (3) @(posedge clk);
        check("min_cs_low", last_cs_run[1], 33);
        check("min_sclk_high", last_hi_run[1], 1);
        check("min_ldac_low", last_ld_run[1], 1);
        check("min_word", word[1], 16'h8000);
        check("min_rises", rise_cnt[1] - b_rise, 32);

        // MSB inversion
        b_fd = fd_cnt[2];
        pulse(2, 16'h8000);
        wait_cnt("inv_fd1", K_FD, 2, b_fd + 1, 200);
        repeat (5) @(posedge clk);
        check("inv_word_8000", word[2], 16'h0000);
        pulse(2, 16'h7FFF);
        wait_cnt("inv_fd2", K_FD, 2, b_fd + 2, 200);
        repeat (5) @(posedge clk);
        check("inv_word_7fff", word[2], 16'hFFFF);

        // Reset mid-frame after the 7th rising edge
        b_rise = rise_cnt[0]; b_fd = fd_cnt[0]; b_ld = ld_fall[0];
        pulse(0, 16'h5A5A);
        wait_cnt("mid_rise7", K_RISE, 0, b_rise + 7, 100);
        #2 rst_n = 1'b0;
        #1;
        check("mid_cs_n", cs_n_w[0], 1'b1);
        check("mid_sclk", sclk_w[0], 1'b0);
        check("mid_ldac_n", ldac_w[0], 1'b1);
        check("mid_ready", rdy_w, 3'b000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("mid_no_ldac", ld_fall[0] - b_ld, 0);
        check("mid_no_frame_done", fd_cnt[0] - b_fd, 0);
        b_rise = rise_cnt[0]; b_fd = fd_cnt[0];
        pulse(0, 16'h1234);
        wait_cnt("mid_fd", K_FD, 0, b_fd + 1, 200);
        repeat (4) @(posedge clk);
        check("mid_word", word[0], 16'h1234);
        check("mid_rises", rise_cnt[0] - b_rise, 16);
        check("mid_cs_low", last_cs_run[0], 66);
        check("mid_ldac_low", last_ld_run[0], 2);

        // Idle hold
        b_tog0 = tog[0]; b_tog1 = tog[1]; b_tog2 = tog[2];
        repeat (100) @(posedge clk);
        #1;
        check("idle_tog_a", tog[0] - b_tog0, 0);
        check("idle_tog_b", tog[1] - b_tog1, 0);
        check("idle_tog_c", tog[2] - b_tog2, 0);
        check("idle_ready", rdy_w, 3'b111);
        check("idle_cs_n", cs_n_w, 3'b111);
        check("idle_sclk", sclk_w, 3'b000);
        check("idle_ldac_n", ldac_w, 3'b111);

        check("sdo_edge_a", viol[0], 0);
        check("sdo_edge_b", viol[1], 0);
        check("sdo_edge_c", viol[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_spi_driver.md
DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2: idle clk cycles with cs_n high after the LDAC pulse; legal range 0..255.
REQ-003 The block SHALL have parameter MSB_INVERT, default 0: 1 = invert din[15] at capture (two's complement to offset binary).
REQ-004 The block SHALL have port clk, input, 1: single system clock, same clock as the DDS datapath.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port din, input, 16: DAC sample (dac_dds_data from the DDS stage).
REQ-007 The block SHALL have port din_valid, input, 1: din holds a sample offered for transfer.
REQ-008 The block SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-009 The block SHALL have port dac_cs_n, output, 1: DAC chip select, active low.
REQ-010 The block SHALL have port dac_sclk, output, 1: serial clock, idle low.
REQ-011 The block SHALL have port dac_sdo, output, 1: serial data, MSB first.
REQ-012 The block SHALL have port dac_ldac_n, output, 1: DAC load strobe, active low.
REQ-013 The block SHALL have port frame_done, output, 1: one-cycle pulse at the end of each LATCH state.

Function
REQ-014 The transfer SHALL occur on a cycle where din_valid=1 and din_ready=1; din_ready SHALL be 1 only in IDLE.
REQ-015 The FSM SHALL use states IDLE, SETUP, SHIFT, LATCH and GAP.
REQ-016 On transfer, din (MSB optionally inverted) SHALL be registered into a 16-bit shift register and the FSM SHALL enter SETUP on the next edge.
REQ-017 din_valid while not in IDLE SHALL be ignored; no sample is queued and none is dropped silently, because din_ready=0.
REQ-018 In SETUP, dac_cs_n SHALL be 0, dac_sclk 0 and dac_sdo = shift[15], for exactly CLK_DIV cycles; the FSM then enters SHIFT.
REQ-019 In SHIFT, each of 16 bits SHALL take 2*CLK_DIV cycles: dac_sclk low for CLK_DIV, then high for CLK_DIV.
REQ-020 dac_sdo SHALL change only on a cycle where dac_sclk goes low (the shift occurs on the falling edge); the DAC samples on the rising edge.
REQ-021 After the 16th high phase, dac_sclk SHALL return to 0, dac_cs_n SHALL go to 1 on the same cycle, and the FSM SHALL enter LATCH.
REQ-022 In LATCH, dac_ldac_n SHALL be 0 for CLK_DIV cycles; frame_done SHALL pulse on the last LATCH cycle.
REQ-023 The FSM SHALL then enter GAP for GAP_CYCLES cycles (skipped when 0), then IDLE.
REQ-024 dac_cs_n low duration SHALL equal 33*CLK_DIV cycles.
REQ-025 The accept-to-accept period SHALL equal 1+34*CLK_DIV+GAP_CYCLES cycles when din_valid is held high.
REQ-026 Latency from the accept edge to dac_cs_n falling SHALL be 1 cycle.
REQ-027 The bit counter SHALL be 5 bits and the half-period counter 8 bits; neither SHALL wrap within a frame.
REQ-028 All outputs SHALL be registered, with no combinational path from din or din_valid to any dac_* output.
REQ-029 din_ready SHALL be decoded from the state register only.

Reset
REQ-030 While rst_n=0, the outputs SHALL hold: state IDLE, dac_cs_n=1, dac_sclk=0, dac_sdo=0, dac_ldac_n=1, frame_done=0, din_ready=0.
REQ-031 din_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no LDAC pulse and no frame_done.

Structure
REQ-033 The shared package dds_pkg SHALL hold: DAC_WIDTH=16, the FSM state encodings, and the CLK_DIV/GAP_CYCLES range limits.
REQ-034 One sub-module SHALL be used: sclk_tick_gen, the half-period counter emitting a one-cycle tick every CLK_DIV cycles, restarted by the FSM on each state entry.
REQ-035 An out-of-range parameter SHALL cause an elaboration-time error.

Verification
REQ-036 Basic frame: CLK_DIV=2, GAP_CYCLES=2, din=0xA5C3 pulsed once -> 16 dac_sclk rising edges; sdo sampled at rising edges = 1010_0101_1100_0011; dac_cs_n low 66 cycles; dac_ldac_n low 2 cycles; one frame_done pulse.
REQ-037 Back-to-back: din_valid held high with din=0x0001 then 0xFFFF -> accepts 71 cycles apart; second frame bits all 1; din changes while busy are ignored.
REQ-038 Minimum divider: CLK_DIV=1, GAP_CYCLES=0, din=0x8000 -> dac_sclk period 2 cycles; dac_cs_n low 33 cycles; accept-to-accept 35 cycles.
REQ-039 MSB_INVERT=1, din=0x8000 -> shifted word 0x0000; din=0x7FFF -> shifted word 0xFFFF.
REQ-040 Reset mid-frame: rst_n low after the 7th rising edge -> same-cycle dac_cs_n=1, dac_sclk=0, no dac_ldac_n pulse; after release, a new din=0x1234 frame completes correctly.
REQ-041 Idle hold: din_valid=0 for 100 cycles -> din_ready=1, dac_cs_n=1, dac_sclk=0 and dac_ldac_n=1 throughout, with no toggling.
